// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl
//   Multi-cycle MIPS main control FSM. It decodes the IR opcode and sequences
//   the datapath through fetch, decode, and the per-class execute/memory/
//   writeback steps. It issues the 2-bit ALU op to the ALU-control decoder and
//   consumes the ALU zero flag for branch resolution.
//
//   Optional feature: define MIPS_BNE_EN to make opcode 5 (bne) legal. bne
//   shares the BRANCH state with beq, and its PC enable uses the inverted zero
//   flag.
//
// Ports
//   clk          in   clock, rising edge
//   rst          in   synchronous active-high reset
//   opcode[5:0]  in   IR[31:26], held stable from DECODE until the next FETCH
//   zero         in   ALU zero flag
//   pc_en        out  PC load enable (unconditional write or taken branch)
//   iord         out  memory address select (0=PC, 1=ALUOut)
//   mem_read     out  memory read strobe
//   mem_write    out  memory write strobe
//   ir_write     out  instruction register load
//   reg_dst      out  destination register select (0=rt, 1=rd)
//   mem_to_reg   out  register write data select (0=ALUOut, 1=MDR)
//   reg_write    out  register file write enable
//   alu_src_a    out  ALU A select (0=PC, 1=regA)
//   alu_src_b    out  ALU B select (00=regB, 01=4, 10=imm, 11=imm<<2)
//   alu_op       out  ALU op (00=add, 01=sub, 10=use funct)
//   pc_src       out  PC source (00=ALU result, 01=ALUOut, 10=jump target)
//   illegal_op   out  one-cycle pulse in DECODE on an undecodable opcode
//   state        out  current state encoding, for debug
//   instr_count  out  retired-instruction counter, wraps modulo 2^CNT_W
module mips_multicycle_ctrl #(
  parameter logic [5:0] OP_RTYPE = 6'd0,
  parameter logic [5:0] OP_LW    = 6'd35,
  parameter logic [5:0] OP_SW    = 6'd43,
  parameter logic [5:0] OP_BEQ   = 6'd4,
  parameter logic [5:0] OP_J     = 6'd2,
  parameter int         CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic             zero,
  output logic             pc_en,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_src,
  output logic             illegal_op,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9
  } state_t;

`ifdef MIPS_BNE_EN
  localparam logic [5:0] OP_BNE = 6'd5;
`endif

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] count_reg;
  logic             retire;
  logic             branch_taken;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_FETCH;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (retire) count_reg <= count_reg + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // bne (when enabled) resolves on the inverted zero flag; beq on zero.
  always_comb begin
    branch_taken = zero;
`ifdef MIPS_BNE_EN
    if (opcode == OP_BNE) branch_taken = ~zero;
`endif
  end

  always_comb begin
    state_next = S_FETCH;
    retire     = 1'b0;
    pc_en      = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    pc_src     = 2'b00;
    illegal_op = 1'b0;

    case (state_reg)
      S_FETCH: begin
        mem_read   = 1'b1;
        ir_write   = 1'b1;
        pc_en      = 1'b1;
        alu_src_b  = 2'b01;
        state_next = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        if (opcode == OP_LW || opcode == OP_SW) state_next = S_MEMADR;
        else if (opcode == OP_RTYPE)            state_next = S_EXEC;
        else if (opcode == OP_BEQ)              state_next = S_BRANCH;
`ifdef MIPS_BNE_EN
        else if (opcode == OP_BNE)              state_next = S_BRANCH;
`endif
        else if (opcode == OP_J)                state_next = S_JUMP;
        else begin
          // Undecodable: drop straight back to FETCH without retiring.
          illegal_op = 1'b1;
          state_next = S_FETCH;
        end
      end
      S_MEMADR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        state_next = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mem_read   = 1'b1;
        iord       = 1'b1;
        state_next = S_MEMWB;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        retire    = 1'b1;
      end
      S_EXEC: begin
        alu_src_a  = 1'b1;
        alu_op     = 2'b10;
        state_next = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        retire    = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        pc_src    = 2'b01;
        pc_en     = branch_taken;
        retire    = 1'b1;
      end
      S_JUMP: begin
        pc_src = 2'b10;
        pc_en  = 1'b1;
        retire = 1'b1;
      end
      default: state_next = S_FETCH;
    endcase

    // During reset no strobe may fire and the muxes sit at their FETCH values.
    if (rst) begin
      pc_en      = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      illegal_op = 1'b0;
      iord       = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b01;
      alu_op     = 2'b00;
      pc_src     = 2'b00;
    end
  end

  assign state       = state_reg;
  assign instr_count = count_reg;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
module tb_mips_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  opcode;
  logic        zero;
  logic        pc_en, iord, mem_read, mem_write, ir_write, reg_dst;
  logic        mem_to_reg, reg_write, alu_src_a, illegal_op;
  logic [1:0]  alu_src_b, alu_op, pc_src;
  logic [3:0]  state;
  logic [15:0] instr_count;

  mips_multicycle_ctrl dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero),
    .pc_en(pc_en), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .pc_src(pc_src), .illegal_op(illegal_op),
    .state(state), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  // Control bundle, MSB first:
  // pc_en iord mem_read mem_write ir_write reg_dst mem_to_reg reg_write
  // alu_src_a alu_src_b[1:0] alu_op[1:0] pc_src[1:0] illegal_op
  logic [15:0] ctl;
  assign ctl = {pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
                reg_write, alu_src_a, alu_src_b, alu_op, pc_src, illegal_op};

  localparam logic [15:0] C_RST  = 16'b0_0_0_0_0_0_0_0_0_01_00_00_0;
  localparam logic [15:0] C_FET  = 16'b1_0_1_0_1_0_0_0_0_01_00_00_0;
  localparam logic [15:0] C_DEC  = 16'b0_0_0_0_0_0_0_0_0_11_00_00_0;
  localparam logic [15:0] C_ILL  = 16'b0_0_0_0_0_0_0_0_0_11_00_00_1;
  localparam logic [15:0] C_MADR = 16'b0_0_0_0_0_0_0_0_1_10_00_00_0;
  localparam logic [15:0] C_MRD  = 16'b0_1_1_0_0_0_0_0_0_00_00_00_0;
  localparam logic [15:0] C_MWB  = 16'b0_0_0_0_0_0_1_1_0_00_00_00_0;
  localparam logic [15:0] C_MWR  = 16'b0_1_0_1_0_0_0_0_0_00_00_00_0;
  localparam logic [15:0] C_EXE  = 16'b0_0_0_0_0_0_0_0_1_00_10_00_0;
  localparam logic [15:0] C_AWB  = 16'b0_0_0_0_0_1_0_1_0_00_00_00_0;
  localparam logic [15:0] C_BR0  = 16'b0_0_0_0_0_0_0_0_1_00_01_01_0;
  localparam logic [15:0] C_BR1  = 16'b1_0_0_0_0_0_0_0_1_00_01_01_0;
  localparam logic [15:0] C_JMP  = 16'b1_0_0_0_0_0_0_0_0_00_00_10_0;

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic        z;
    logic [3:0]  st;
    logic [15:0] ctl;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic add(input logic r, input logic [5:0] op, input logic z,
                     input logic [3:0] st, input logic [15:0] c, input logic [15:0] cnt);
    vec_t v;
    v.rst = r; v.op = op; v.z = z; v.st = st; v.ctl = c; v.cnt = cnt;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [15:0] act,
                     input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s #%0d: got 0x%0h, expected 0x%0h", name, idx, act, exp);
    end
  endtask

  // Reference model: instruction-level behaviour derived from the opcode.
  function automatic bit is_legal(input logic [5:0] op);
    if (op == 6'd0 || op == 6'd35 || op == 6'd43 || op == 6'd4 || op == 6'd2) return 1;
`ifdef MIPS_BNE_EN
    if (op == 6'd5) return 1;
`endif
    return 0;
  endfunction

  function automatic int latency(input logic [5:0] op);
    if (!is_legal(op)) return 2;
    case (op)
      6'd35:       return 5;
      6'd43, 6'd0: return 4;
      default:     return 3;
    endcase
  endfunction

  int model_cnt;

  initial begin
    rst = 1'b1; opcode = 6'd0; zero = 1'b0;
    @(posedge clk); #1;

    // Directed per-cycle table.
    add(1, 6'd0, 0, 0, C_RST, 0);
    add(1, 6'd0, 0, 0, C_RST, 0);
    // lw
    add(0, 6'd35, 0, 0, C_FET, 0);
    add(0, 6'd35, 0, 1, C_DEC, 0);
    add(0, 6'd35, 0, 2, C_MADR, 0);
    add(0, 6'd35, 0, 3, C_MRD, 0);
    add(0, 6'd35, 0, 4, C_MWB, 0);
    // R-type
    add(0, 6'd0, 0, 0, C_FET, 1);
    add(0, 6'd0, 0, 1, C_DEC, 1);
    add(0, 6'd0, 0, 6, C_EXE, 1);
    add(0, 6'd0, 0, 7, C_AWB, 1);
    // beq taken, then not taken
    add(0, 6'd4, 1, 0, C_FET, 2);
    add(0, 6'd4, 1, 1, C_DEC, 2);
    add(0, 6'd4, 1, 8, C_BR1, 2);
    add(0, 6'd4, 0, 0, C_FET, 3);
    add(0, 6'd4, 0, 1, C_DEC, 3);
    add(0, 6'd4, 0, 8, C_BR0, 3);
    // illegal opcode 63
    add(0, 6'd63, 0, 0, C_FET, 4);
    add(0, 6'd63, 0, 1, C_ILL, 4);
    // sw aborted by reset in MEMWR
    add(0, 6'd43, 0, 0, C_FET, 4);
    add(0, 6'd43, 0, 1, C_DEC, 4);
    add(0, 6'd43, 0, 2, C_MADR, 4);
    add(1, 6'd43, 0, 5, C_RST, 4);
    // j after reset
    add(0, 6'd2, 0, 0, C_FET, 0);
    add(0, 6'd2, 0, 1, C_DEC, 0);
    add(0, 6'd2, 0, 9, C_JMP, 0);
    add(0, 6'd0, 0, 0, C_FET, 1);

    for (int i = 0; i < tbl.size(); i++) begin
      rst = tbl[i].rst; opcode = tbl[i].op; zero = tbl[i].z;
      #1;
      chk("state", i, {12'd0, state}, {12'd0, tbl[i].st});
      chk("ctl", i, ctl, tbl[i].ctl);
      chk("count", i, instr_count, tbl[i].cnt);
      $display("vec %0d: rst=%0d op=%0d z=%0d state=%0d ctl=%04h cnt=%0d",
               i, tbl[i].rst, tbl[i].op, tbl[i].z, state, ctl, instr_count);
      @(posedge clk); #1;
    end

    // Randomized instruction stream against the instruction-level model.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_cnt = 0;
    for (int k = 0; k < 200; k++) begin
      logic [5:0] op;
      logic       z;
      int         sel, cyc, n_pc, n_rw, n_mw, n_mr, n_ill;
      int         e_pc, e_rw, e_mw, e_mr, e_ill;
      bit         leg;
      sel = $urandom_range(0, 6);
      case (sel)
        0: op = 6'd0;
        1: op = 6'd35;
        2: op = 6'd43;
        3: op = 6'd4;
        4: op = 6'd2;
        5: op = 6'd5;
        default: begin
          op = 6'($urandom_range(0, 63));
          while (is_legal(op)) op = 6'($urandom_range(0, 63));
        end
      endcase
      z = 1'($urandom_range(0, 1));
      opcode = op; zero = z;
      #1;
      chk("rnd_start", k, {12'd0, state}, 16'd0);

      n_pc = 0; n_rw = 0; n_mw = 0; n_mr = 0; n_ill = 0; cyc = 0;
      do begin
        n_pc  += int'(pc_en);
        n_rw  += int'(reg_write);
        n_mw  += int'(mem_write);
        n_mr  += int'(mem_read);
        n_ill += int'(illegal_op);
        @(posedge clk); #1;
        cyc++;
      end while (state != 4'd0 && cyc < 12);

      leg   = is_legal(op);
      e_ill = leg ? 0 : 1;
      e_rw  = (op == 6'd35 || op == 6'd0) ? 1 : 0;
      e_mw  = (op == 6'd43) ? 1 : 0;
      e_mr  = (op == 6'd35) ? 2 : 1;
      e_pc  = 1;
      if (op == 6'd2) e_pc++;
      if (op == 6'd4 && z) e_pc++;
      if (op == 6'd5 && leg && !z) e_pc++;
      if (leg) model_cnt = (model_cnt + 1) % 65536;

      chk("rnd_latency", k, 16'(cyc), 16'(latency(op)));
      chk("rnd_pc_en", k, 16'(n_pc), 16'(e_pc));
      chk("rnd_reg_write", k, 16'(n_rw), 16'(e_rw));
      chk("rnd_mem_write", k, 16'(n_mw), 16'(e_mw));
      chk("rnd_mem_read", k, 16'(n_mr), 16'(e_mr));
      chk("rnd_illegal", k, 16'(n_ill), 16'(e_ill));
      chk("rnd_count", k, instr_count, 16'(model_cnt));
      $display("instr %0d: op=%0d z=%0d cycles=%0d pc_en=%0d cnt=%0d",
               k, op, z, cyc, n_pc, instr_count);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
